// File: rtl/tetris_key_decoder_pkg.sv
// tetris_input_pkg: shared constants for the Tetris keyboard front end.
//   - PS/2 set-2 prefix bytes and the key codes the game reacts to
//   - prefix FSM state encoding
//   - key_e: internal key index, which is also the bit position of the key in
//     the decoder's held/command vectors
//   - decode_key(): maps an (extended?, code) pair to a key_e
package tetris_input_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;  // extended
  localparam logic [7:0] SC_RIGHT = 8'h74;  // extended
  localparam logic [7:0] SC_UP    = 8'h75;  // extended
  localparam logic [7:0] SC_DOWN  = 8'h72;  // extended
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_P     = 8'h4D;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  localparam int NUM_KEYS = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } prefix_state_e;

  // Order matters: the low four indices form the external held port
  // {down, up, right, left}.
  typedef enum logic [2:0] {
    K_LEFT  = 3'd0,
    K_RIGHT = 3'd1,
    K_UP    = 3'd2,
    K_DOWN  = 3'd3,
    K_SPACE = 3'd4,
    K_P     = 3'd5,
    K_ENTER = 3'd6,
    K_NONE  = 3'd7
  } key_e;

  function automatic key_e decode_key(input logic ext, input logic [7:0] code);
    key_e k;
    k = K_NONE;
    if (ext) begin
      case (code)
        SC_LEFT:  k = K_LEFT;
        SC_RIGHT: k = K_RIGHT;
        SC_UP:    k = K_UP;
        SC_DOWN:  k = K_DOWN;
        default:  k = K_NONE;
      endcase
    end else begin
      case (code)
        SC_SPACE: k = K_SPACE;
        SC_P:     k = K_P;
        SC_ENTER: k = K_ENTER;
        default:  k = K_NONE;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/tetris_key_decoder_if.sv
// tetris_key_decoder_if: byte input and command outputs of the key decoder.
//   scan_code / scan_code_valid : PS/2 set-2 byte and its one-cycle strobe
//   cmd_*                        : one-cycle game command pulses
//   held                         : {down, up, right, left} held flags
// master = keyboard/game side, slave = decoder.
interface tetris_key_decoder_if;
  logic [7:0] scan_code;
  logic       scan_code_valid;
  logic       cmd_left;
  logic       cmd_right;
  logic       cmd_rotate;
  logic       cmd_soft_drop;
  logic       cmd_hard_drop;
  logic       cmd_pause;
  logic       cmd_start;
  logic [3:0] held;

  modport master (
    output scan_code, scan_code_valid,
    input  cmd_left, cmd_right, cmd_rotate, cmd_soft_drop,
    input  cmd_hard_drop, cmd_pause, cmd_start, held
  );

  modport slave (
    input  scan_code, scan_code_valid,
    output cmd_left, cmd_right, cmd_rotate, cmd_soft_drop,
    output cmd_hard_drop, cmd_pause, cmd_start, held
  );
endinterface

// File: rtl/tetris_key_decoder_timer.sv
// key_repeat_timer: auto-repeat tick generator for a held key.
//   CLOCK_50 / resetn : clock, synchronous active-low reset
//   start             : (re)arm the timer this cycle; never ticks on start
//   hold              : key held after this cycle's events; low clears it
//   tick              : combinational, high on the cycle a repeat is due
// After start, the first tick comes FIRST_DELAY cycles later, then one every
// PERIOD cycles while hold stays high.
module key_repeat_timer #(
  parameter int unsigned FIRST_DELAY = 10,
  parameter int unsigned PERIOD      = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic start,
  input  logic hold,
  output logic tick
);

  localparam logic [CNT_W-1:0] FIRST_C  = CNT_W'(FIRST_DELAY);
  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);

  // cnt_q == 0 means idle; otherwise it counts cycles since the last arm/tick,
  // starting at 1, so it never exceeds the active limit and cannot wrap.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rep_q, rep_d;   // past the first delay, in periodic phase
  logic [CNT_W-1:0] limit;

  assign limit = rep_q ? PERIOD_C : FIRST_C;
  assign tick  = hold && !start && (cnt_q != '0) && (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q;
    rep_d = rep_q;
    if (!hold) begin
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (start) begin
      cnt_d = CNT_W'(1);
      rep_d = 1'b0;
    end else if (tick) begin
      cnt_d = CNT_W'(1);
      rep_d = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      cnt_q <= '0;
      rep_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rep_q <= rep_d;
    end
  end

endmodule

// File: rtl/tetris_key_decoder.sv
// tetris_key_decoder: PS/2 set-2 byte stream -> Tetris command pulses.
//   CLOCK_50 : clock
//   resetn   : synchronous active-low reset
//   kb       : slave side of tetris_key_decoder_if (bytes in, commands out)
// A prefix FSM turns bytes into make/release events, per-key held bits
// suppress typematic repeats, and two key_repeat_timer instances produce
// horizontal DAS/ARR and soft-drop repeats. All outputs are registered, so a
// press pulses its command on the cycle after the strobe.
module tetris_key_decoder
  import tetris_input_pkg::*;
#(
  parameter int unsigned DAS_DELAY   = 7_500_000,
  parameter int unsigned ARR_PERIOD  = 2_500_000,
  parameter int unsigned SOFT_PERIOD = 2_500_000
) (
  input logic                  CLOCK_50,
  input logic                  resetn,
  tetris_key_decoder_if.slave  kb
);

  localparam int unsigned MAX_A = (DAS_DELAY > ARR_PERIOD) ? DAS_DELAY : ARR_PERIOD;
  localparam int unsigned MAX_P = (MAX_A > SOFT_PERIOD) ? MAX_A : SOFT_PERIOD;
  localparam int unsigned CNT_W = $clog2(MAX_P + 1);

  prefix_state_e         state_q, state_d;
  logic [NUM_KEYS-1:0]   held_q, held_d;
  logic [NUM_KEYS-1:0]   cmd_q, cmd_d;
  logic                  owner_q, owner_d;   // horizontal repeat owner: 0 left, 1 right

  logic                  ev_make, ev_brk, ev_ext;
  key_e                  key;
  logic [NUM_KEYS-1:0]   make_v, brk_v, press_v;
  logic                  h_start, h_hold, h_tick;
  logic                  s_start, s_hold, s_tick;

  always_comb begin
    state_d = state_q;
    ev_make = 1'b0;
    ev_brk  = 1'b0;
    ev_ext  = 1'b0;
    if (kb.scan_code_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (kb.scan_code == SC_EXT)      state_d = ST_EXT;
          else if (kb.scan_code == SC_BRK) state_d = ST_BRK;
          else                             ev_make = 1'b1;
        end
        ST_EXT: begin
          if (kb.scan_code == SC_BRK)      state_d = ST_EXT_BRK;
          else if (kb.scan_code == SC_EXT) state_d = ST_EXT;
          else begin
            ev_make = 1'b1;
            ev_ext  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          ev_brk  = 1'b1;
          state_d = ST_IDLE;
        end
        ST_EXT_BRK: begin
          ev_brk  = 1'b1;
          ev_ext  = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end

    key    = decode_key(ev_ext, kb.scan_code);
    make_v = '0;
    brk_v  = '0;
    if (key != K_NONE) begin
      if (ev_make) make_v = NUM_KEYS'(1) << key;
      if (ev_brk)  brk_v  = NUM_KEYS'(1) << key;
    end

    // Only a make of a key not already held counts as a press.
    press_v = make_v & ~held_q;
    held_d  = (held_q | make_v) & ~brk_v;

    // Horizontal ownership: a new press takes the timer; releasing the owner
    // hands it to the other direction if that one is still down.
    owner_d = owner_q;
    h_start = 1'b0;
    if (press_v[K_LEFT]) begin
      owner_d = 1'b0;
      h_start = 1'b1;
    end else if (press_v[K_RIGHT]) begin
      owner_d = 1'b1;
      h_start = 1'b1;
    end else if (brk_v[K_LEFT] && !owner_q && held_q[K_RIGHT]) begin
      owner_d = 1'b1;
      h_start = 1'b1;
    end else if (brk_v[K_RIGHT] && owner_q && held_q[K_LEFT]) begin
      owner_d = 1'b0;
      h_start = 1'b1;
    end
    // Hold uses next-state flags so a release cancels a repeat due that cycle.
    h_hold  = owner_d ? held_d[K_RIGHT] : held_d[K_LEFT];
    s_start = press_v[K_DOWN];
    s_hold  = held_d[K_DOWN];

    // Timers never tick on a start cycle, so owner_q is the live owner here.
    cmd_d          = press_v;
    cmd_d[K_LEFT]  = cmd_d[K_LEFT]  | (h_tick & ~owner_q);
    cmd_d[K_RIGHT] = cmd_d[K_RIGHT] | (h_tick & owner_q);
    cmd_d[K_DOWN]  = cmd_d[K_DOWN]  | s_tick;
  end

  key_repeat_timer #(
    .FIRST_DELAY (DAS_DELAY),
    .PERIOD      (ARR_PERIOD),
    .CNT_W       (CNT_W)
  ) u_horiz_timer (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .start    (h_start),
    .hold     (h_hold),
    .tick     (h_tick)
  );

  key_repeat_timer #(
    .FIRST_DELAY (SOFT_PERIOD),
    .PERIOD      (SOFT_PERIOD),
    .CNT_W       (CNT_W)
  ) u_soft_timer (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .start    (s_start),
    .hold     (s_hold),
    .tick     (s_tick)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      held_q  <= '0;
      cmd_q   <= '0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      cmd_q   <= cmd_d;
      owner_q <= owner_d;
    end
  end

  assign kb.cmd_left      = cmd_q[K_LEFT];
  assign kb.cmd_right     = cmd_q[K_RIGHT];
  assign kb.cmd_rotate    = cmd_q[K_UP];
  assign kb.cmd_soft_drop = cmd_q[K_DOWN];
  assign kb.cmd_hard_drop = cmd_q[K_SPACE];
  assign kb.cmd_pause     = cmd_q[K_P];
  assign kb.cmd_start     = cmd_q[K_ENTER];
  assign kb.held          = held_q[3:0];

endmodule

// File: tb/tb_tetris_key_decoder.sv
module tb_tetris_key_decoder;

  localparam int DAS  = 10;
  localparam int ARR  = 4;
  localparam int SOFT = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  tetris_key_decoder_if bus();

  tetris_key_decoder #(
    .DAS_DELAY   (DAS),
    .ARR_PERIOD  (ARR),
    .SOFT_PERIOD (SOFT)
  ) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .kb       (bus)
  );

  // cmd bit order: {start, pause, hard, soft, rotate, right, left}
  typedef struct packed {
    logic [6:0] cmd;
    logic [3:0] held;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   t        = 0;

  // Reference model: prefix flags, held flags, and the cycle at which each
  // repeat stream was last (re)armed; repeats follow from elapsed time.
  bit m_ext, m_brk;
  bit mheld[7];
  int owner, h_start, s_start;

  function automatic int key_of(input bit ext, input logic [7:0] code);
    if (ext) begin
      if (code == 8'h6B) return 0;
      if (code == 8'h74) return 1;
      if (code == 8'h75) return 2;
      if (code == 8'h72) return 3;
    end else begin
      if (code == 8'h29) return 4;
      if (code == 8'h4D) return 5;
      if (code == 8'h5A) return 6;
    end
    return -1;
  endfunction

  function automatic obs_t model_step(input bit rst, input bit v, input logic [7:0] code);
    obs_t o;
    int   k, n;
    bit   mk, rl;
    o  = '0;
    mk = 0;
    rl = 0;
    k  = -1;
    if (rst) begin
      m_ext = 0; m_brk = 0; owner = 0; h_start = 0; s_start = 0;
      for (int i = 0; i < 7; i++) mheld[i] = 0;
      return o;
    end
    if (v) begin
      if (m_brk) begin
        rl = 1; k = key_of(m_ext, code); m_ext = 0; m_brk = 0;
      end else if (code == 8'hE0) m_ext = 1;
      else if (code == 8'hF0) m_brk = 1;
      else begin
        mk = 1; k = key_of(m_ext, code); m_ext = 0;
      end
    end
    if (k >= 0 && mk && !mheld[k]) begin
      mheld[k] = 1;
      o.cmd[k] = 1'b1;
      if (k < 2) begin owner = k; h_start = t; end
      if (k == 3) s_start = t;
    end
    if (k >= 0 && rl) begin
      mheld[k] = 0;
      if (k == owner && mheld[1-owner]) begin owner = 1 - owner; h_start = t; end
    end
    if (mheld[owner]) begin
      n = t - h_start;
      if (n >= DAS && (n - DAS) % ARR == 0) o.cmd[owner] = 1'b1;
    end
    if (mheld[3]) begin
      n = t - s_start;
      if (n >= SOFT && (n - SOFT) % SOFT == 0) o.cmd[3] = 1'b1;
    end
    o.held = {mheld[3], mheld[2], mheld[1], mheld[0]};
    return o;
  endfunction

  task automatic step(input bit rst, input bit v, input logic [7:0] code);
    @(negedge clk);
    resetn              = !rst;
    bus.scan_code_valid = v;
    bus.scan_code       = code;
    exp_q.push_back(model_step(rst, v, code));
    t++;
  endtask

  task automatic send(input logic [7:0] code);
    step(0, 1, code);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00);
  endtask

  // Monitor: each cycle's registered outputs are compared with the oldest
  // expected entry.
  always begin
    obs_t e, g;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = '{cmd: {bus.cmd_start, bus.cmd_pause, bus.cmd_hard_drop, bus.cmd_soft_drop,
                  bus.cmd_rotate, bus.cmd_right, bus.cmd_left},
            held: bus.held};
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL outputs @%0t: cmd got %b exp %b, held got %b exp %b",
                 $time, g.cmd, e.cmd, g.held, e.held);
      end
    end
  end

  logic [7:0] pool [12];

  initial begin
    bus.scan_code_valid = 1'b0;
    bus.scan_code       = 8'h00;
    pool = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h72,
             8'h29, 8'h4D, 8'h5A, 8'h1C, 8'hE1, 8'hAA};

    step(1, 0, 8'h00);
    step(1, 0, 8'h00);
    idle(2);

    // Left press, DAS/ARR repeats, release
    send(8'hE0); send(8'h6B); idle(25);
    send(8'hE0); send(8'hF0); send(8'h6B); idle(15);

    // Space typematic, release, re-press
    send(8'h29); idle(2); send(8'h29); send(8'h29); idle(2);
    send(8'hF0); send(8'h29); idle(2); send(8'h29); idle(2);
    send(8'hF0); send(8'h29); idle(2);

    // Left held, right takes over, right released, left resumes
    send(8'hE0); send(8'h6B); idle(5);
    send(8'hE0); send(8'h74); idle(12);
    send(8'hE0); send(8'hF0); send(8'h74); idle(15);
    send(8'hE0); send(8'hF0); send(8'h6B); idle(5);

    // Soft drop repeats, release
    send(8'hE0); send(8'h72); idle(12);
    send(8'hE0); send(8'hF0); send(8'h72); idle(6);

    // Unmapped codes, P and Enter
    send(8'h1C); send(8'hF0); send(8'h1C); send(8'hE1); idle(3);
    send(8'h4D); send(8'h5A); send(8'hF0); send(8'h4D); send(8'hF0); send(8'h5A); idle(2);

    // Reset discards an E0 prefix
    send(8'hE0); step(1, 0, 8'h00); send(8'h75); idle(2);
    send(8'hE0); send(8'h75); idle(2);
    send(8'hE0); send(8'hF0); send(8'h75); idle(2);

    // Randomized byte stream with occasional resets
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] c;
      bit rst_now, v;
      rst_now = ($urandom_range(0, 299) == 0);
      v       = ($urandom_range(0, 2) == 0);
      c       = ($urandom_range(0, 7) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
      step(rst_now, v, c);
    end
    idle(3);

    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
